sdr_lane_pipe: RTL and testbench

- Parametrised multi-lane SDR I/O register pipeline; next generation of the single-lane sysio SDR datapath.
- Sits between the pad-side SDR input registers and core logic inside the sysio test top.
- Adds over the single-lane design: per-lane enables, configurable pipeline depth, operating modes (pass / freeze / invert / linear-check) and a built-in linear-pattern checker with a saturating error counter.

---
 rtl/sdr_pkg.sv | 31 +++
 rtl/sdr_lane_chk.sv | 56 +++++
 rtl/sdr_lane_pipe.sv | 119 +++++++++++
 tb/tb_sdr_lane_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
// ============================================================================
// Module : sdr_pkg
// Brief  : Shared mode encodings, counter default and popcount helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sdr_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_FREEZE = 2'b01,
        MODE_INV    = 2'b10,
        MODE_LIN    = 2'b11
    } sdr_mode_e;

    localparam int c_ERR_W_DEF = 16;

    // Lane count never exceeds 16, so a fixed 16-bit popcount covers every build.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int k = 0; k < 16; k++) begin
            n = n + {4'b0000, v[k]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdr_lane_chk.sv
// ============================================================================
// Module : sdr_lane_chk
// Brief  : Per-lane linear-pattern checker: expected counter, compare, sticky flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sdr_lane_chk #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_start,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_mis,
    output logic             o_err
);

    logic [WIDTH-1:0] r_exp;
    logic             r_err;
    logic [WIDTH-1:0] w_exp_eff;
    logic             w_mis;

    // On the entry edge the sequence restarts at zero for the beat sampled there.
    always_comb begin
        w_exp_eff = i_start ? '0 : r_exp;
        w_mis     = i_en && (i_data != w_exp_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_en) begin
                r_exp <= w_exp_eff + WIDTH'(1);
            end else if (i_start) begin
                r_exp <= '0;
            end

            if (i_clr) begin
                r_err <= 1'b0;
            end else if (w_mis) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_mis = w_mis;
    assign o_err = r_err;

endmodule

`default_nettype wire

// File: rtl/sdr_lane_pipe.sv
// ============================================================================
// Module : sdr_lane_pipe
// Brief  : Multi-lane SDR register pipeline with modes and linear-pattern check.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sdr_lane_pipe
    import sdr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 2,
    parameter int ERR_W = c_ERR_W_DEF
) (
    input  logic                   clkin,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] datain,
    input  logic                   din_valid,
    input  logic [LANES-1:0]       lane_en,
    input  logic [1:0]             mode,
    input  logic                   err_clr,
    output logic [LANES*WIDTH-1:0] q,
    output logic                   q_valid,
    output logic [LANES-1:0]       lane_err,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int                SUM_W     = ERR_W + 5;
    localparam logic [ERR_W-1:0]  c_CNT_MAX = '1;

    logic [LANES*WIDTH-1:0] r_pipe [DEPTH];
    logic                   r_vld  [DEPTH];
    sdr_mode_e              r_mode_prev;
    logic [ERR_W-1:0]       r_cnt;

    sdr_mode_e              w_mode;
    logic                   w_lin;
    logic                   w_lin_entry;
    logic                   w_v0;
    logic [LANES-1:0]       w_mis;
    logic [LANES*WIDTH-1:0] w_s0_next;
    logic [4:0]             w_pop;
    logic [SUM_W-1:0]       w_sum;
    logic [ERR_W-1:0]       w_cnt_next;

    assign w_mode      = sdr_mode_e'(mode);
    assign w_lin       = (w_mode == MODE_LIN);
    assign w_lin_entry = w_lin && (r_mode_prev != MODE_LIN);
    assign w_v0        = din_valid && (w_mode != MODE_FREEZE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w_din;
        logic             w_load;

        assign w_din  = datain[i*WIDTH +: WIDTH];
        assign w_load = din_valid && lane_en[i] && (w_mode != MODE_FREEZE);

        // A lane that does not load keeps its stage-0 value, which then repeats downstream.
        assign w_s0_next[i*WIDTH +: WIDTH] =
            w_load ? ((w_mode == MODE_INV) ? ~w_din : w_din)
                   : r_pipe[0][i*WIDTH +: WIDTH];

        sdr_lane_chk #(
            .WIDTH (WIDTH)
        ) u_chk (
            .clk     (clkin),
            .rst_n   (reset),
            .i_en    (w_lin && din_valid && lane_en[i]),
            .i_start (w_lin_entry),
            .i_clr   (err_clr),
            .i_data  (w_din),
            .o_mis   (w_mis[i]),
            .o_err   (lane_err[i])
        );
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_pipe[k] <= '0;
                r_vld[k]  <= 1'b0;
            end
            r_mode_prev <= MODE_PASS;
        end else begin
            r_pipe[0] <= w_s0_next;
            r_vld[0]  <= w_v0;
            for (int k = 1; k < DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
            r_mode_prev <= w_mode;
        end
    end

    // Widened sum so several simultaneous mismatches cannot wrap before saturating.
    always_comb begin
        w_pop      = popcount16(16'(w_mis));
        w_sum      = SUM_W'(r_cnt) + SUM_W'(w_pop);
        w_cnt_next = (w_sum > SUM_W'(c_CNT_MAX)) ? c_CNT_MAX : w_sum[ERR_W-1:0];
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (err_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign q       = r_pipe[DEPTH-1];
    assign q_valid = r_vld[DEPTH-1];
    assign err_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sdr_lane_pipe.sv
// ============================================================================
// Module : tb_sdr_lane_pipe
// Brief  : Self-checking bench: vector table, directed corner cases, random vs model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sdr_lane_pipe;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int ERR_W = 4;
    localparam int DW    = WIDTH * LANES;

    logic          clkin     = 1'b0;
    logic          reset     = 1'b0;
    logic [DW-1:0] datain    = '0;
    logic          din_valid = 1'b0;
    logic [3:0]    lane_en   = '0;
    logic [1:0]    mode      = 2'b00;
    logic          err_clr   = 1'b0;
    logic [DW-1:0] q;
    logic          q_valid;
    logic [3:0]    lane_err;
    logic [3:0]    err_cnt;

    sdr_lane_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .DEPTH (DEPTH),
        .ERR_W (ERR_W)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .datain    (datain),
        .din_valid (din_valid),
        .lane_en   (lane_en),
        .mode      (mode),
        .err_clr   (err_clr),
        .q         (q),
        .q_valid   (q_valid),
        .lane_err  (lane_err),
        .err_cnt   (err_cnt)
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;

    // Reference state: DEPTH-deep history of stage-0 words, per-lane expected counters.
    logic [DW-1:0] m_hist [DEPTH];
    logic          m_vh   [DEPTH];
    logic [7:0]    m_exp  [LANES];
    logic [3:0]    m_err;
    int            m_cnt;
    logic [1:0]    m_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_hist[k] = '0;
            m_vh[k]   = 1'b0;
        end
        for (int i = 0; i < LANES; i++) m_exp[i] = '0;
        m_err  = '0;
        m_cnt  = 0;
        m_prev = 2'b00;
    endtask

    task automatic model_step();
        logic [DW-1:0] s0;
        logic [7:0]    d;
        int            mis;
        if (!reset) begin
            model_reset();
        end else begin
            s0  = m_hist[0];
            mis = 0;
            for (int i = 0; i < LANES; i++) begin
                d = datain[i*WIDTH +: WIDTH];
                if (din_valid && lane_en[i] && mode != 2'b01)
                    s0[i*WIDTH +: WIDTH] = (mode == 2'b10) ? ~d : d;
            end
            if (mode == 2'b11) begin
                if (m_prev != 2'b11)
                    for (int i = 0; i < LANES; i++) m_exp[i] = 8'd0;
                for (int i = 0; i < LANES; i++) begin
                    d = datain[i*WIDTH +: WIDTH];
                    if (din_valid && lane_en[i]) begin
                        if (d != m_exp[i]) begin
                            m_err[i] = 1'b1;
                            mis++;
                        end
                        m_exp[i] = m_exp[i] + 8'd1;
                    end
                end
            end
            if (err_clr) begin
                m_cnt = 0;
                m_err = '0;
            end else begin
                m_cnt = (m_cnt + mis > 15) ? 15 : m_cnt + mis;
            end
            m_prev = mode;
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_hist[k] = m_hist[k-1];
                m_vh[k]   = m_vh[k-1];
            end
            m_hist[0] = s0;
            m_vh[0]   = din_valid && (mode != 2'b01);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        model_step();
        #1;
        chk("model_q",        64'(q),        64'(m_hist[DEPTH-1]));
        chk("model_q_valid",  64'(q_valid),  64'(m_vh[DEPTH-1]));
        chk("model_lane_err", 64'(lane_err), 64'(m_err));
        chk("model_err_cnt",  64'(err_cnt),  64'(m_cnt));
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [3:0]    en;
        logic          v;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
        logic          qv;
    } vec_t;

    vec_t          tbl [10];
    logic [DW-1:0] frozen;
    logic [7:0]    b;

    initial begin
        model_reset();

        tbl[0] = '{2'b00, 4'hF,    1'b1, 32'h0000_00A5, 32'h0000_0000, 1'b0};
        tbl[1] = '{2'b00, 4'hF,    1'b0, 32'h0000_0000, 32'h0000_00A5, 1'b1};
        tbl[2] = '{2'b00, 4'hF,    1'b0, 32'h0000_0000, 32'h0000_00A5, 1'b0};
        tbl[3] = '{2'b10, 4'b1101, 1'b1, 32'h0F0F_0F0F, 32'h0000_00A5, 1'b0};
        tbl[4] = '{2'b10, 4'b1101, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_00F0, 1'b1};
        tbl[5] = '{2'b00, 4'hF,    1'b1, 32'h1122_3344, 32'hF0F0_00F0, 1'b0};
        tbl[6] = '{2'b10, 4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1122_3344, 1'b1};
        tbl[7] = '{2'b00, 4'hF,    1'b0, 32'h0000_0000, 32'h1122_0044, 1'b1};
        tbl[8] = '{2'b01, 4'hF,    1'b1, 32'hAAAA_AAAA, 32'h1122_0044, 1'b0};
        tbl[9] = '{2'b01, 4'hF,    1'b1, 32'h5555_5555, 32'h1122_0044, 1'b0};

        // Reset held for three edges.
        repeat (3) begin
            cyc();
            chk("rst_q", 64'(q), 64'h0);
            chk("rst_qv", 64'(q_valid), 64'h0);
            chk("rst_cnt", 64'(err_cnt), 64'h0);
        end
        reset = 1'b1;

        for (int r = 0; r < 10; r++) begin
            mode      = tbl[r].mode;
            lane_en   = tbl[r].en;
            din_valid = tbl[r].v;
            datain    = tbl[r].d;
            cyc();
            chk($sformatf("tbl%0d_q", r),  64'(q),       64'(tbl[r].q));
            chk($sformatf("tbl%0d_qv", r), 64'(q_valid), 64'(tbl[r].qv));
            chk($sformatf("tbl%0d_le", r), 64'(lane_err), 64'h0);
        end

        // Linear clean run across the 8-bit wrap.
        mode = 2'b11; lane_en = 4'hF; din_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            b = 8'(k);
            datain = {4{b}};
            cyc();
        end
        chk("lin_clean_cnt", 64'(err_cnt), 64'h0);
        chk("lin_clean_le",  64'(lane_err), 64'h0);

        // Leave and re-enter linear mode, corrupt lane 2 at beat 10.
        mode = 2'b00; din_valid = 1'b0;
        cyc();
        mode = 2'b11; din_valid = 1'b1;
        for (int k = 0; k < 13; k++) begin
            b = 8'(k);
            datain = {4{b}};
            if (k == 10) datain[23:16] = 8'h55;
            cyc();
        end
        chk("lin_fault_le",  64'(lane_err), 64'h4);
        chk("lin_fault_cnt", 64'(err_cnt), 64'h1);

        // Saturation: lanes 0/1 wrong on 10 beats, then clear coinciding with a mismatch.
        err_clr = 1'b1; din_valid = 1'b0;
        cyc();
        chk("clr_cnt", 64'(err_cnt), 64'h0);
        err_clr = 1'b0; din_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b = 8'(13 + k);
            datain = {b, b, b ^ 8'h80, b ^ 8'h80};
            cyc();
        end
        chk("sat_cnt", 64'(err_cnt), 64'hF);
        chk("sat_le",  64'(lane_err), 64'h3);
        b = 8'd23;
        datain = {b, b, b ^ 8'h80, b ^ 8'h80};
        cyc();
        chk("sat_hold_cnt", 64'(err_cnt), 64'hF);
        err_clr = 1'b1;
        datain = 32'hDEAD_BEEF;
        cyc();
        chk("clr_win_cnt", 64'(err_cnt), 64'h0);
        chk("clr_win_le",  64'(lane_err), 64'h0);
        err_clr = 1'b0;

        // Build up errors, then freeze with data still changing.
        datain = 32'hFFFF_FFFF;
        cyc();
        chk("pre_freeze_cnt", 64'(err_cnt), 64'h4);
        frozen = m_hist[0];
        mode = 2'b01;
        for (int k = 0; k < 6; k++) begin
            datain = DW'($urandom);
            cyc();
            if (k >= DEPTH - 1) begin
                chk("freeze_q",  64'(q), 64'(frozen));
                chk("freeze_qv", 64'(q_valid), 64'h0);
            end
        end

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        chk("arst_q",   64'(q), 64'h0);
        chk("arst_qv",  64'(q_valid), 64'h0);
        chk("arst_cnt", 64'(err_cnt), 64'h0);
        chk("arst_le",  64'(lane_err), 64'h0);
        model_reset();
        cyc();
        cyc();
        reset = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            mode      = 2'($urandom_range(0, 3));
            lane_en   = 4'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < LANES; i++)
                datain[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_exp[i];
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
